gate_bus_pipe: RTL and testbench
================================

Name: gate_bus_pipe

Overview:
- Parametrised N-input bitwise gate bus with per-input bubble (inversion) mask and a runtime-selectable operation.
- Adds a 2-stage valid/ready pipeline and an optional running accumulator, so multi-beat reductions such as flag merges and parity folds run without external registers.
- Sits in the datapath helper library beside the combinational gate buses.
- Used by the CPU and its test harness wherever a registered, flow-controlled logic reduction is needed.

Parameters:
- NrOfBits, 32, width of each input operand and of Result.
- NrOfInputs, 4, number of operand channels; legal range 2..8.
- BubblesMask, 0, NrOfInputs-bit mask; bit i=1 inverts channel i before reduction.

Ports:
- Clock  in  1  single clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Inputs  in  NrOfInputs*NrOfBits  operand channels; channel i occupies bits [i*NrOfBits +: NrOfBits].
- Op  in  2  operation select: 00 AND, 01 OR, 10 XOR, 11 XNOR (inverted XOR).
- Acc  in  1  1 = fold this beat into the accumulator; 0 = start a fresh result.
- InValid  in  1  upstream has a beat on Inputs/Op/Acc.
- InReady  out  1  block accepts the beat this cycle.
- OutValid  out  1  Result holds a valid beat.
- OutReady  in  1  downstream consumes the beat this cycle.
- Result  out  NrOfBits  reduced, optionally accumulated, value.

Behaviour:
- Interface: one clock (Clock); reset (Reset) is asynchronous and active-high.
- Reset values:
  - OutValid=0 and Result=0.
  - Internal stage-A valid=0 and AccReg=0.
  - InReady=1 combinationally while Reset is deasserted and the pipe is empty.
- Accept and emit rules:
  - Beat accepted when InValid & InReady.
  - Beat emitted when OutValid & OutReady.
- Stage A (capture), on accept:
  - Registers bubbled channels: ch_i ^ {NrOfBits{BubblesMask[i]}}.
  - Registers Op and Acc, and sets A_valid.
- Stage B (compute):
  - Loads when A_valid & (!OutValid | OutReady).
  - Computes r = bitwise Op-reduction over all NrOfInputs channels. XNOR is ~(XOR reduction).
  - If stage-A Acc=1: Result <= r OPacc AccReg, where OPacc is AND/OR/XOR/XNOR per the captured Op.
  - If stage-A Acc=0: Result <= r.
  - AccReg <= the same value as Result on every stage-B load. AccReg changes only on stage-B loads.
  - OutValid <= 1 on load.
  - OutValid <= 0 when emitted and no new load occurs in the same cycle.
- InReady = !A_valid | (!OutValid | OutReady). This is a pure pipeline stall with no skid; InReady depends combinationally on OutReady.
- Latency: accept at edge k gives OutValid=1 after edge k+1, i.e. 2 cycles. Throughput is 1 beat/cycle when OutReady=1.
- Stall: while OutValid & !OutReady, Result and OutValid hold stable. Stage A holds its beat, and InReady=0 once stage A is full.
- Simultaneous emit and load in the same cycle: the new beat replaces the old one, OutValid stays 1, and there are no bubbles.
- Simultaneous accept and stage-A→B transfer: stage A takes the new beat while B takes the old one.
- Ordering: beats leave in acceptance order with no loss or duplication. Op, Acc and operands travel with their beat.
- Accumulation spans emitted beats, in order. Changing Op between accumulated beats is legal; each fold uses its own beat's Op.
- Reset mid-operation clears both stages and AccReg asynchronously; in-flight beats are discarded. The first beat after reset with Acc=1 folds against 0.
- Inputs, Op and Acc are don't-care when InValid=0. X on them must not reach state.

Test Plan (NrOfBits=8, NrOfInputs=4, BubblesMask=0 unless stated):
1. Op=01, Acc=0, Inputs={08,04,02,01}, OutReady=1 → Result=0F with OutValid=1 exactly 2 cycles after accept. Back-to-back Op=00 beat {FF,F0,3C,F8} → 30 on the next cycle.
2. BubblesMask=4'b0001, Op=00, Inputs ch0..3={00,FF,FF,FF} → FF. Same with ch0=FF → 00.
3. Accumulate XOR, Op=10, single nonzero channel:
   - Beat1 Acc=0 ch0=0F → 0F.
   - Beat2 Acc=1 ch0=F0 → FF.
   - Beat3 Acc=1 ch0=FF → 00.
   - Beat4 Acc=0 ch0=55 → 55.
4. OutReady=0 for 6 cycles while offering 3 OR beats (01, 02, 04 on ch0):
   - Two beats are accepted, then InReady=0.
   - Result stays 01 throughout the stall.
   - After OutReady=1, Result reads 01, 02, 04 in consecutive cycles.
5. Reset pulsed mid-cycle while OutValid=1 and A_valid=1:
   - OutValid=0, Result=00 and InReady=1 immediately, without waiting for a clock edge.
   - Next Op=01 Acc=1 ch0=3C → 3C.
6. XNOR, Inputs={AA,55,00,00} → 00. Then Acc=1 with same inputs → FF, i.e. ~(00^00).

Source files
------------

// File: rtl/gate_bus_pipe.sv
// Registered N-input bitwise gate bus: per-channel bubble mask, runtime-selectable
// AND/OR/XOR/XNOR reduction, 2-stage valid/ready pipeline and a running accumulator.
module gate_bus_pipe #(
  parameter int                    NrOfBits    = 32,
  parameter int                    NrOfInputs  = 4,
  parameter logic [NrOfInputs-1:0] BubblesMask = '0
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic [NrOfInputs*NrOfBits-1:0] i_inputs,
  input  logic [1:0]                     i_op,
  input  logic                           i_acc,
  input  logic                           i_in_valid,
  output logic                           o_in_ready,
  output logic                           o_out_valid,
  input  logic                           i_out_ready,
  output logic [NrOfBits-1:0]            o_result
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;

  function automatic logic [NrOfBits-1:0] reduce_op(
    input logic [NrOfInputs*NrOfBits-1:0] ch,
    input logic [1:0]                     op
  );
    logic [NrOfBits-1:0] v_and;
    logic [NrOfBits-1:0] v_or;
    logic [NrOfBits-1:0] v_xor;
    v_and = '1;
    v_or  = '0;
    v_xor = '0;
    for (int i = 0; i < NrOfInputs; i++) begin
      v_and = v_and & ch[i*NrOfBits +: NrOfBits];
      v_or  = v_or  | ch[i*NrOfBits +: NrOfBits];
      v_xor = v_xor ^ ch[i*NrOfBits +: NrOfBits];
    end
    case (op)
      OP_AND:  reduce_op = v_and;
      OP_OR:   reduce_op = v_or;
      OP_XOR:  reduce_op = v_xor;
      default: reduce_op = ~v_xor;
    endcase
  endfunction

  function automatic logic [NrOfBits-1:0] fold_op(
    input logic [NrOfBits-1:0] a,
    input logic [NrOfBits-1:0] b,
    input logic [1:0]          op
  );
    case (op)
      OP_AND:  fold_op = a & b;
      OP_OR:   fold_op = a | b;
      OP_XOR:  fold_op = a ^ b;
      default: fold_op = ~(a ^ b);
    endcase
  endfunction

  logic [NrOfInputs*NrOfBits-1:0] w_bubble_bits;
  logic [NrOfInputs*NrOfBits-1:0] w_bubbled;
  logic                           w_accept;
  logic                           w_load_p1;
  logic [NrOfBits-1:0]            w_reduced;
  logic [NrOfBits-1:0]            w_next_result;

  logic [NrOfInputs*NrOfBits-1:0] r_ch_p0;
  logic [1:0]                     r_op_p0;
  logic                           r_acc_p0;
  logic                           r_vld_p0;
  logic [NrOfBits-1:0]            r_result_p1;
  logic [NrOfBits-1:0]            r_accreg_p1;
  logic                           r_vld_p1;

  for (genvar g = 0; g < NrOfInputs; g++) begin : g_bubble
    assign w_bubble_bits[g*NrOfBits +: NrOfBits] = {NrOfBits{BubblesMask[g]}};
  end

  assign w_bubbled  = i_inputs ^ w_bubble_bits;
  // Pure stall, no skid: stage A may refill whenever stage B will drain this cycle.
  assign o_in_ready = !r_vld_p0 | !r_vld_p1 | i_out_ready;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_load_p1  = r_vld_p0 & (!r_vld_p1 | i_out_ready);

  // Stage A: capture bubbled operands with their Op/Acc
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_accept | (r_vld_p0 & !w_load_p1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_accept) begin
      r_ch_p0  <= w_bubbled;
      r_op_p0  <= i_op;
      r_acc_p0 <= i_acc;
    end
  end

  // Stage B: reduce, optionally fold into the accumulator
  assign w_reduced     = reduce_op(r_ch_p0, r_op_p0);
  assign w_next_result = r_acc_p0 ? fold_op(w_reduced, r_accreg_p1, r_op_p0) : w_reduced;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_vld_p1    <= 1'b0;
      r_result_p1 <= '0;
      r_accreg_p1 <= '0;
    end else begin
      r_vld_p1 <= w_load_p1 | (r_vld_p1 & !i_out_ready);
      if (w_load_p1) begin
        r_result_p1 <= w_next_result;
        r_accreg_p1 <= w_next_result;
      end
    end
  end

  assign o_out_valid = r_vld_p1;
  assign o_result    = r_result_p1;

endmodule

// File: tb/tb_gate_bus_pipe.sv
// Directed bench for gate_bus_pipe (8-bit, 4 channels) plus a bubbled-ch0 instance.
module tb_gate_bus_pipe;

  logic        clk;
  logic        rst;
  logic [31:0] inputs;
  logic [1:0]  op;
  logic        acc;
  logic        in_valid;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  result;
  logic        in_ready_b;
  logic        out_valid_b;
  logic [7:0]  result_b;

  int n_vec = 0;
  int n_err = 0;

  gate_bus_pipe #(.NrOfBits(8), .NrOfInputs(4), .BubblesMask(4'b0000)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_inputs(inputs), .i_op(op), .i_acc(acc),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_result(result)
  );

  gate_bus_pipe #(.NrOfBits(8), .NrOfInputs(4), .BubblesMask(4'b0001)) u_dut_b (
    .i_clock(clk), .i_reset(rst), .i_inputs(inputs), .i_op(op), .i_acc(acc),
    .i_in_valid(in_valid), .o_in_ready(in_ready_b), .o_out_valid(out_valid_b),
    .i_out_ready(out_ready), .o_result(result_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] o, input logic a);
    in_valid = 1'b1;
    inputs   = d;
    op       = o;
    acc      = a;
  endtask

  // One isolated beat with OutReady=1: accept, then result visible one edge later.
  task automatic beat(input string tag, input logic [31:0] d, input logic [1:0] o,
                      input logic a, input logic [7:0] exp);
    drive(d, o, a);
    step();
    in_valid = 1'b0;
    inputs   = 'x;
    op       = 'x;
    acc      = 1'bx;
    step();
    chk({tag, "_vld"}, out_valid, 1);
    chk(tag, result, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; inputs = '0; op = '0; acc = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 8'h00);
    #10;
    rst = 1'b0;
    #1;
    chk("rst_rdy", in_ready, 1);
    step();

    // 1: latency and back-to-back throughput
    drive({8'h08, 8'h04, 8'h02, 8'h01}, 2'b01, 1'b0);
    chk("t1_rdy", in_ready, 1);
    step();
    chk("t1_lat1_vld", out_valid, 0);
    drive({8'hFF, 8'hF0, 8'h3C, 8'hF8}, 2'b00, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t1_or_vld", out_valid, 1);
    chk("t1_or", result, 8'h0F);
    step();
    chk("t1_and_vld", out_valid, 1);
    chk("t1_and", result, 8'h30);
    step();
    chk("t1_drain_vld", out_valid, 0);

    // 2: bubble mask on ch0 (second instance) vs plain instance
    beat("t2a_plain", {8'hFF, 8'hFF, 8'hFF, 8'h00}, 2'b00, 1'b0, 8'h00);
    chk("t2a_bub", result_b, 8'hFF);
    beat("t2b_plain", {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 2'b00, 1'b0, 8'hFF);
    chk("t2b_bub", result_b, 8'h00);

    // 3: XOR accumulation
    beat("t3_b1", 32'h0000_000F, 2'b10, 1'b0, 8'h0F);
    beat("t3_b2", 32'h0000_00F0, 2'b10, 1'b1, 8'hFF);
    beat("t3_b3", 32'h0000_00FF, 2'b10, 1'b1, 8'h00);
    beat("t3_b4", 32'h0000_0055, 2'b10, 1'b0, 8'h55);
    step();

    // 4: downstream stall
    out_ready = 1'b0;
    drive(32'h01, 2'b01, 1'b0);
    chk("t4_rdy0", in_ready, 1);
    step();
    drive(32'h02, 2'b01, 1'b0);
    chk("t4_rdy1", in_ready, 1);
    step();
    drive(32'h04, 2'b01, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("t4_stall_rdy", in_ready, 0);
      chk("t4_stall_vld", out_valid, 1);
      chk("t4_stall_res", result, 8'h01);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_release_rdy", in_ready, 1);
    chk("t4_out1", result, 8'h01);
    step();
    in_valid = 1'b0;
    chk("t4_out2_vld", out_valid, 1);
    chk("t4_out2", result, 8'h02);
    step();
    chk("t4_out3_vld", out_valid, 1);
    chk("t4_out3", result, 8'h04);
    step();
    chk("t4_drain_vld", out_valid, 0);

    // 5: asynchronous reset with both stages full
    out_ready = 1'b0;
    drive(32'h11, 2'b01, 1'b0);
    step();
    drive(32'h22, 2'b01, 1'b0);
    step();
    in_valid = 1'b0;
    chk("t5_pre_vld", out_valid, 1);
    chk("t5_pre_rdy", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_vld", out_valid, 0);
    chk("t5_rst_res", result, 8'h00);
    chk("t5_rst_rdy", in_ready, 1);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("t5_no_stale", out_valid, 0);
    beat("t5_acc0", 32'h0000_003C, 2'b01, 1'b1, 8'h3C);

    // 6: XNOR, then XNOR fold
    beat("t6_xnor", {8'hAA, 8'h55, 8'h00, 8'h00}, 2'b11, 1'b0, 8'h00);
    beat("t6_fold", {8'hAA, 8'h55, 8'h00, 8'h00}, 2'b11, 1'b1, 8'hFF);
    step();
    chk("t6_drain_vld", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
